// File: rtl/rst_seq_ctrl_if.sv
// rst_seq_ctrl_if: software reset request and staged reset/enable outputs of rst_seq_ctrl
//   sw_rst_req      core -> sequencer, software reset request (sync to clk)
//   core_rst_n      sequencer -> core, active-low core reset
//   low_peri_rst_n  sequencer -> peripherals, active-low peripheral reset
//   low_peri_ce     sequencer -> peripherals, one-cycle enable strobe
//   rst_cause       sequencer -> core, 01 power-on/pin, 10 software
//   rst_busy        sequencer -> core, sequence still in progress
interface rst_seq_ctrl_if;
  logic       sw_rst_req;
  logic       core_rst_n;
  logic       low_peri_rst_n;
  logic       low_peri_ce;
  logic [1:0] rst_cause;
  logic       rst_busy;
  modport master (
    input  sw_rst_req,
    output core_rst_n, low_peri_rst_n, low_peri_ce, rst_cause, rst_busy
  );
  modport slave (
    output sw_rst_req,
    input  core_rst_n, low_peri_rst_n, low_peri_ce, rst_cause, rst_busy
  );
endinterface

// File: rtl/rst_seq_ctrl.sv
// rst_seq_ctrl: staged reset sequencer (core then peripherals) with software reset and low-speed clock enable
//   clk    board clock, all logic on its rising edge
//   rst_n  raw reset, asynchronous assert, synchronised release
//   bus    rst_seq_ctrl_if.master: sw_rst_req in; core_rst_n, low_peri_rst_n, low_peri_ce, rst_cause, rst_busy out
module rst_seq_ctrl #(
  parameter int SYNC_STAGES = 2,
  parameter int CORE_DLY    = 16,
  parameter int PERI_DLY    = 16,
  parameter int CE_DIV      = 4,
  parameter int SWRST_LEN   = 32
) (
  input logic            clk,
  input logic            rst_n,
  rst_seq_ctrl_if.master bus
);
  localparam int M1 = CORE_DLY > PERI_DLY ? CORE_DLY : PERI_DLY;
  localparam int M2 = M1 > SWRST_LEN ? M1 : SWRST_LEN;
  localparam int MX = M2 > CE_DIV ? M2 : CE_DIV;
  localparam int W  = $clog2(MX + 1);
  typedef enum logic [2:0] {S_RESET, S_CORE_WAIT, S_PERI_WAIT, S_RUN, S_SWRST} state_t;
  state_t                 state, state_d;
  logic [SYNC_STAGES-1:0] sync;
  logic [W-1:0]           cnt, cnt_d, div, div_d;
  logic                   core_q, core_d, peri_q, peri_d, ce_q, ce_d, sw_req_q, sw_edge;
  logic [1:0]             cause, cause_d;
  assign sw_edge = bus.sw_rst_req & ~sw_req_q;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state    <= S_RESET;
      sync     <= '0;
      cnt      <= '0;
      div      <= '0;
      core_q   <= 1'b0;
      peri_q   <= 1'b0;
      ce_q     <= 1'b0;
      cause    <= 2'b01;
      sw_req_q <= 1'b1;
    end else begin
      state    <= state_d;
      sync     <= {sync[SYNC_STAGES-2:0], 1'b1};
      cnt      <= cnt_d;
      div      <= div_d;
      core_q   <= core_d;
      peri_q   <= peri_d;
      ce_q     <= ce_d;
      cause    <= cause_d;
      sw_req_q <= bus.sw_rst_req;
    end
  // S_RESET exits on the edge that loads the final synchroniser stage, so core
  // release lands SYNC_STAGES+CORE_DLY edges after rst_n deasserts.
  always_comb begin
    state_d = state;
    cnt_d   = cnt;
    core_d  = core_q;
    peri_d  = peri_q;
    cause_d = cause;
    case (state)
      S_RESET:
        if (sync[SYNC_STAGES-2] | sync[SYNC_STAGES-1]) begin
          state_d = S_CORE_WAIT;
          cnt_d   = '0;
        end
      S_CORE_WAIT:
        if (cnt == W'(CORE_DLY - 1)) begin
          state_d = S_PERI_WAIT;
          cnt_d   = '0;
          core_d  = 1'b1;
        end else cnt_d = cnt + 1'b1;
      S_PERI_WAIT:
        if (cnt == W'(PERI_DLY - 1)) begin
          state_d = S_RUN;
          cnt_d   = '0;
          peri_d  = 1'b1;
        end else cnt_d = cnt + 1'b1;
      S_RUN: state_d = S_RUN;
      S_SWRST:
        if (cnt == W'(SWRST_LEN - 1)) begin
          state_d = S_CORE_WAIT;
          cnt_d   = '0;
        end else cnt_d = cnt + 1'b1;
      default: state_d = S_RESET;
    endcase
    if (sw_edge && (state == S_PERI_WAIT || state == S_RUN)) begin
      state_d = S_SWRST;
      cnt_d   = '0;
      core_d  = 1'b0;
      peri_d  = 1'b0;
      cause_d = 2'b10;
    end
    // div tracks (cycles since peri release - 1) mod CE_DIV, aligned with peri_q
    div_d = (peri_d && peri_q && div != W'(CE_DIV - 1)) ? div + 1'b1 : '0;
    ce_d  = peri_d && div_d == W'(CE_DIV - 1);
  end
  assign bus.core_rst_n     = core_q;
  assign bus.low_peri_rst_n = peri_q;
  assign bus.low_peri_ce    = ce_q;
  assign bus.rst_cause      = cause;
  assign bus.rst_busy       = state != S_RUN;
endmodule

// File: tb/tb_rst_seq_ctrl.sv
// tb_rst_seq_ctrl: scoreboard bench for rst_seq_ctrl (CE_DIV=4 and CE_DIV=1 instances)
module tb_rst_seq_ctrl;
  localparam int CE = 4;
  typedef struct {
    int         c;
    logic [4:0] v;
  } ev_t;
  logic clk = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;
  rst_seq_ctrl_if bus0 ();
  rst_seq_ctrl_if bus1 ();
  assign bus1.sw_rst_req = bus0.sw_rst_req;
  rst_seq_ctrl dut0 (.clk(clk), .rst_n(rst_n), .bus(bus0.master));
  rst_seq_ctrl #(.CE_DIV(1)) dut1 (.clk(clk), .rst_n(rst_n), .bus(bus1.master));
  int n_assert = 0, n_fail = 0, cyc = 0, k = 0, c0 = 0, n0 = 0;
  ev_t q[$];
  ev_t e;
  logic [4:0] exp_cur = 5'b00011;
  bit mon_on = 0;
  always @(posedge clk) cyc++;
  task automatic chk5(input string nm, input logic [4:0] got, input logic [4:0] want);
    n_assert++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s @cyc %0d: got %b expected %b", nm, cyc, got, want);
    end
  endtask
  task automatic chk1(input string nm, input logic got, input logic want);
    n_assert++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s @cyc %0d: got %b expected %b", nm, cyc, got, want);
    end
  endtask
  // tuple layout {core_rst_n, low_peri_rst_n, rst_cause[1:0], rst_busy}
  always @(negedge clk)
    if (mon_on) begin
      while (q.size() > 0 && q[0].c <= cyc) begin
        e = q.pop_front();
        exp_cur = e.v;
      end
      chk5("outs_div4", {bus0.core_rst_n, bus0.low_peri_rst_n, bus0.rst_cause, bus0.rst_busy}, exp_cur);
      chk5("outs_div1", {bus1.core_rst_n, bus1.low_peri_rst_n, bus1.rst_cause, bus1.rst_busy}, exp_cur);
      k = exp_cur[3] ? k + 1 : 0;
      chk1("ce_div4", bus0.low_peri_ce, k > 0 && k % CE == 0);
      chk1("ce_div1", bus1.low_peri_ce, exp_cur[3]);
    end
  task automatic imm_reset();
    chk5("async_outs_div4", {bus0.core_rst_n, bus0.low_peri_rst_n, bus0.rst_cause, bus0.rst_busy}, 5'b00011);
    chk5("async_outs_div1", {bus1.core_rst_n, bus1.low_peri_rst_n, bus1.rst_cause, bus1.rst_busy}, 5'b00011);
    chk1("async_ce_div4", bus0.low_peri_ce, 1'b0);
    chk1("async_ce_div1", bus1.low_peri_ce, 1'b0);
  endtask
  task automatic wait_to(input int t);
    while (cyc < t) @(negedge clk);
  endtask
  task automatic push_power_on(input int c);
    q.push_back('{c + 18, 5'b10011});
    q.push_back('{c + 34, 5'b11010});
  endtask
  task automatic push_sw(input int n);
    q.push_back('{n, 5'b00101});
    q.push_back('{n + 48, 5'b10101});
    q.push_back('{n + 64, 5'b11100});
  endtask
  initial begin
    bus0.sw_rst_req = 1'b0;
    #2 rst_n = 1'b0;
    #1 imm_reset();
    mon_on = 1;
    repeat (5) @(negedge clk);
    rst_n = 1'b1;
    c0 = cyc;
    push_power_on(c0);
    wait_to(c0 + 5);
    bus0.sw_rst_req = 1'b1;
    @(negedge clk);
    bus0.sw_rst_req = 1'b0;
    wait_to(c0 + 45);
    bus0.sw_rst_req = 1'b1;
    n0 = cyc + 1;
    push_sw(n0);
    @(negedge clk);
    bus0.sw_rst_req = 1'b0;
    wait_to(n0 + 5);
    bus0.sw_rst_req = 1'b1;
    @(negedge clk);
    bus0.sw_rst_req = 1'b0;
    wait_to(n0 + 70);
    bus0.sw_rst_req = 1'b1;
    n0 = cyc + 1;
    q.push_back('{n0, 5'b00101});
    @(negedge clk);
    bus0.sw_rst_req = 1'b0;
    wait_to(n0 + 9);
    @(posedge clk);
    #2 rst_n = 1'b0;
    q.push_back('{cyc, 5'b00011});
    #1 imm_reset();
    bus0.sw_rst_req = 1'b1;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    c0 = cyc;
    push_power_on(c0);
    wait_to(c0 + 45);
    bus0.sw_rst_req = 1'b0;
    repeat (3) @(negedge clk);
    bus0.sw_rst_req = 1'b1;
    n0 = cyc + 1;
    push_sw(n0);
    wait_to(n0 + 70);
    @(posedge clk);
    #2 rst_n = 1'b0;
    q.push_back('{cyc, 5'b00011});
    #1 imm_reset();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    c0 = cyc;
    push_power_on(c0);
    wait_to(c0 + 50);
    bus0.sw_rst_req = 1'b0;
    repeat (2) @(negedge clk);
    n_assert++;
    if (q.size() != 0) begin
      n_fail++;
      $display("FAIL queue_empty: got %0d pending expected 0", q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
